// File: rtl/dcache_nway.sv
// N-way set-associative write-back / write-allocate data cache with true-LRU
// replacement, pipelined hits and a single-beat line write-back handshake.
module dcache_nway #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 256,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cpu_req_i,
    input  logic                         cpu_op_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W/8-1:0]          cpu_wr_en_i,
    input  logic [DATA_W-1:0]            cpu_wr_data_i,
    output logic [DATA_W-1:0]            cpu_rd_data_o,
    output logic                         cpu_addr_ack_o,
    output logic                         cpu_data_ack_o,
    output logic                         ram_rd_req_o,
    output logic [ADDR_W-1:0]            ram_rd_addr_o,
    input  logic                         ram_rd_rdy_i,
    input  logic [DATA_W-1:0]            ram_rd_data_i,
    input  logic                         ram_rd_valid_i,
    output logic                         ram_wr_req_o,
    output logic [ADDR_W-1:0]            ram_wr_addr_o,
    output logic [DATA_W*LINE_WORDS-1:0] ram_wr_data_o,
    input  logic                         ram_wr_rdy_i
);
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned BOFF_W = $clog2(BYTES);
    localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS * BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WADR_W = ADDR_W - BOFF_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} state_t;
    state_t state, state_nxt;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [DATA_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];

    logic              req_op;
    logic [WADR_W-1:0] req_waddr;
    logic [BYTES-1:0]  req_be;
    logic [DATA_W-1:0] req_wdata;
    logic [WAY_W-1:0]  miss_way;
    logic              rd_pend;
    logic [WSEL_W-1:0] beat_cnt;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  rtag;
    logic [WSEL_W-1:0] wsel;
    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic [WAY_W-1:0]  lru_way;
    logic              victim_dirty;
    logic [DATA_W-1:0] hit_word;
    logic [DATA_W-1:0] hit_merged;
    logic [DATA_W-1:0] fill_word;
    logic [DATA_W*LINE_WORDS-1:0] victim_line;
    logic              lru_en;
    logic [WAY_W-1:0]  lru_acc;
    logic              beat_ok;
    logic              last_beat;
    logic              unused_addr;

    assign unused_addr = ^cpu_addr_i[BOFF_W-1:0];

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [BYTES-1:0]  be,
                                                input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < int'(BYTES); b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    assign idx  = req_waddr[OFF_W-BOFF_W +: IDX_W];
    assign rtag = req_waddr[WADR_W-1 -: TAG_W];
    assign wsel = req_waddr[WSEL_W-1:0];

    // Tag compare across all ways and victim choice (lowest invalid, else LRU)
    always_comb begin
        hit_vec    = '0;
        hit_way    = '0;
        victim_way = lru_way;
        for (int w = 0; w < int'(WAYS); w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[w][idx] == rtag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--)
            if (!valid_q[idx][w]) victim_way = WAY_W'(w);
    end

    assign hit          = |hit_vec;
    assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];
    assign hit_word     = data_q[hit_way][idx][wsel];
    assign hit_merged   = merge(hit_word, req_be, req_wdata);
    assign last_beat    = (beat_cnt == WSEL_W'(LINE_WORDS - 1));
    assign fill_word    = (req_op && (beat_cnt == wsel))
                          ? merge(ram_rd_data_i, req_be, req_wdata) : ram_rd_data_i;

    always_comb begin
        victim_line = '0;
        for (int k = 0; k < int'(LINE_WORDS); k++)
            victim_line[k*DATA_W +: DATA_W] = data_q[miss_way][idx][k];
    end

    // Ages per set form a permutation; age WAYS-1 marks the LRU way
    generate
        if (WAYS > 1) begin : g_lru
            logic [WAY_W-1:0] age_q [SETS][WAYS];
            logic [WAY_W-1:0] acc_age;

            assign acc_age = age_q[idx][lru_acc];

            always_comb begin
                lru_way = '0;
                for (int w = 0; w < int'(WAYS); w++)
                    if (age_q[idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < int'(SETS); s++)
                        for (int w = 0; w < int'(WAYS); w++)
                            age_q[s][w] <= WAY_W'(w);
                end else if (lru_en) begin
                    for (int w = 0; w < int'(WAYS); w++) begin
                        if (WAY_W'(w) == lru_acc)
                            age_q[idx][w] <= '0;
                        else if (age_q[idx][w] < acc_age)
                            age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
                    end
                end
            end
        end else begin : g_no_lru
            logic unused_lru;
            assign lru_way    = '0;
            assign unused_lru = lru_en ^ (|lru_acc);
        end
    endgenerate

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        cpu_addr_ack_o = 1'b0;
        cpu_data_ack_o = 1'b0;
        cpu_rd_data_o  = '0;
        ram_rd_req_o   = 1'b0;
        ram_rd_addr_o  = '0;
        ram_wr_req_o   = 1'b0;
        ram_wr_addr_o  = '0;
        ram_wr_data_o  = '0;
        lru_en         = 1'b0;
        lru_acc        = hit_way;
        beat_ok        = 1'b0;
        case (state)
            IDLE: begin
                cpu_addr_ack_o = cpu_req_i && rst_n;
                if (cpu_addr_ack_o) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_data_ack_o = 1'b1;
                    cpu_rd_data_o  = req_op ? hit_merged : hit_word;
                    cpu_addr_ack_o = cpu_req_i && rst_n;
                    lru_en         = 1'b1;
                    state_nxt      = cpu_addr_ack_o ? LOOKUP : IDLE;
                end else begin
                    state_nxt = victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                ram_wr_req_o  = 1'b1;
                ram_wr_addr_o = {tag_q[miss_way][idx], idx, OFF_W'(0)};
                ram_wr_data_o = victim_line;
                if (ram_wr_rdy_i) state_nxt = REFILL;
            end
            REFILL: begin
                ram_rd_req_o = rd_pend;
                if (rd_pend) ram_rd_addr_o = {rtag, idx, OFF_W'(0)};
                beat_ok = ram_rd_valid_i && (!rd_pend || ram_rd_rdy_i);
                if (beat_ok && last_beat) begin
                    lru_en    = 1'b1;
                    lru_acc   = miss_way;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cpu_data_ack_o = 1'b1;
                cpu_rd_data_o  = data_q[miss_way][idx][wsel];
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, request buffer and line status bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_op    <= 1'b0;
            req_waddr <= '0;
            req_be    <= '0;
            req_wdata <= '0;
            miss_way  <= '0;
            rd_pend   <= 1'b0;
            beat_cnt  <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (cpu_addr_ack_o) begin
                req_op    <= cpu_op_i;
                req_waddr <= cpu_addr_i[ADDR_W-1:BOFF_W];
                req_be    <= cpu_wr_en_i;
                req_wdata <= cpu_wr_data_i;
            end
            if (state == LOOKUP && hit && req_op)
                dirty_q[idx][hit_way] <= 1'b1;
            if (state == LOOKUP && !hit) begin
                miss_way                 <= victim_way;
                valid_q[idx][victim_way] <= 1'b0;
            end
            if (state != REFILL && state_nxt == REFILL) begin
                rd_pend  <= 1'b1;
                beat_cnt <= '0;
            end
            if (state == REFILL) begin
                if (ram_rd_rdy_i) rd_pend <= 1'b0;
                if (beat_ok) beat_cnt <= beat_cnt + WSEL_W'(1);
                if (beat_ok && last_beat) begin
                    valid_q[idx][miss_way] <= 1'b1;
                    dirty_q[idx][miss_way] <= req_op;
                end
            end
        end
    end

    // Line storage: write-hit merge, refill beats and tag install
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == LOOKUP && hit && req_op)
                data_q[hit_way][idx][wsel] <= hit_merged;
            if (state == REFILL && beat_ok) begin
                data_q[miss_way][idx][beat_cnt] <= fill_word;
                if (last_beat) tag_q[miss_way][idx] <= rtag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Bench for dcache_nway: directed scenarios plus random traffic, checked
// against a flat-memory + recency-list model of a 2-way cache.
module tb_dcache_nway;
    localparam int NW = 2;
    localparam int NS = 256;
    localparam int LW = 4;

    logic         clk;
    logic         rst_n;
    logic         cpu_req_i;
    logic         cpu_op_i;
    logic [31:0]  cpu_addr_i;
    logic [3:0]   cpu_wr_en_i;
    logic [31:0]  cpu_wr_data_i;
    logic [31:0]  cpu_rd_data_o;
    logic         cpu_addr_ack_o;
    logic         cpu_data_ack_o;
    logic         ram_rd_req_o;
    logic [31:0]  ram_rd_addr_o;
    logic         ram_rd_rdy_i;
    logic [31:0]  ram_rd_data_i;
    logic         ram_rd_valid_i;
    logic         ram_wr_req_o;
    logic [31:0]  ram_wr_addr_o;
    logic [127:0] ram_wr_data_o;
    logic         ram_wr_rdy_i;

    dcache_nway dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_i      (cpu_req_i),
        .cpu_op_i       (cpu_op_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_wr_en_i    (cpu_wr_en_i),
        .cpu_wr_data_i  (cpu_wr_data_i),
        .cpu_rd_data_o  (cpu_rd_data_o),
        .cpu_addr_ack_o (cpu_addr_ack_o),
        .cpu_data_ack_o (cpu_data_ack_o),
        .ram_rd_req_o   (ram_rd_req_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_rdy_i   (ram_rd_rdy_i),
        .ram_rd_data_i  (ram_rd_data_i),
        .ram_rd_valid_i (ram_rd_valid_i),
        .ram_wr_req_o   (ram_wr_req_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_wr_rdy_i   (ram_wr_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: backing memory, cache contents, recency order (MRU first)
    bit [31:0] mem [bit [31:0]];
    bit        mv   [NW][NS];
    bit        md   [NW][NS];
    bit [19:0] mt   [NW][NS];
    bit [31:0] mdat [NW][NS][LW];
    int        rec  [NS][$];

    bit        pq_op   [$];
    bit [31:0] pq_addr [$];
    bit [3:0]  pq_be   [$];
    bit [31:0] pq_wd   [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                mv[w][s] = 1'b0;
                md[w][s] = 1'b0;
            end
            rec[s].delete();
            for (int w = 0; w < NW; w++) rec[s].push_back(w);
        end
    endtask

    task automatic model_access(input bit op, input bit [31:0] addr, input bit [3:0] be,
                                input bit [31:0] wd, output bit hit, output bit wb,
                                output bit [31:0] wb_addr, output bit [127:0] wb_line,
                                output bit [31:0] rd_addr, output bit [127:0] fill,
                                output bit [31:0] rdata);
        bit [7:0]  s8;
        bit [19:0] t;
        int        s;
        int        wi;
        int        way;
        int        pos;
        s8 = addr[11:4];
        s  = int'(s8);
        t  = addr[31:12];
        wi = int'(addr[3:2]);
        way = -1;
        wb = 1'b0; wb_addr = '0; wb_line = '0; rd_addr = '0; fill = '0;
        for (int w = 0; w < NW; w++)
            if (mv[w][s] && mt[w][s] == t) way = w;
        hit = (way >= 0);
        if (!hit) begin
            for (int w = NW - 1; w >= 0; w--)
                if (!mv[w][s]) way = w;
            if (way < 0) way = rec[s][NW-1];
            if (mv[way][s] && md[way][s]) begin
                wb      = 1'b1;
                wb_addr = {mt[way][s], s8, 4'h0};
                for (int k = 0; k < LW; k++) begin
                    wb_line[k*32 +: 32] = mdat[way][s][k];
                    mem[wb_addr + 32'(4*k)] = mdat[way][s][k];
                end
            end
            rd_addr = {t, s8, 4'h0};
            for (int k = 0; k < LW; k++) begin
                mdat[way][s][k]  = mem_rd(rd_addr + 32'(4*k));
                fill[k*32 +: 32] = mdat[way][s][k];
            end
            mv[way][s] = 1'b1;
            md[way][s] = 1'b0;
            mt[way][s] = t;
        end
        if (op) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdat[way][s][wi][b*8 +: 8] = wd[b*8 +: 8];
            md[way][s] = 1'b1;
        end
        rdata = mdat[way][s][wi];
        pos = 0;
        for (int i = 0; i < rec[s].size(); i++)
            if (rec[s][i] == way) pos = i;
        rec[s].delete(pos);
        rec[s].push_front(way);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr_ack"}, cpu_addr_ack_o, 0);
        chk({tag, "_data_ack"}, cpu_data_ack_o, 0);
        chk({tag, "_rd_data"},  cpu_rd_data_o, 0);
        chk({tag, "_rd_req"},   ram_rd_req_o, 0);
        chk({tag, "_rd_addr"},  ram_rd_addr_o, 0);
        chk({tag, "_wr_req"},   ram_wr_req_o, 0);
        chk({tag, "_wr_addr"},  ram_wr_addr_o, 0);
        chk({tag, "_wr_data"},  ram_wr_data_o, 0);
    endtask

    // One CPU access; misses are serviced by the bench acting as RAM
    task automatic access(input bit op, input bit [31:0] addr, input bit [3:0] be,
                          input bit [31:0] wd, input int wb_dly, input int abort_beats);
        bit         hit, wb, pend;
        bit [31:0]  wb_addr, rd_addr, rdata;
        bit [127:0] wb_line, fill;
        int         beat, hs_wait;
        model_access(op, addr, be, wd, hit, wb, wb_addr, wb_line, rd_addr, fill, rdata);

        @(posedge clk); #1;
        cpu_req_i = 1'b1; cpu_op_i = op; cpu_addr_i = addr;
        cpu_wr_en_i = be; cpu_wr_data_i = wd;
        ram_rd_valid_i = 1'b1; ram_rd_data_i = 32'hBADB_AD00;
        @(negedge clk);
        chk("addr_ack", cpu_addr_ack_o, 1);
        @(posedge clk); #1;
        ram_rd_valid_i = 1'b0;
        if (hit) cpu_req_i = 1'b0;
        else begin
            cpu_op_i = 1'b0; cpu_addr_i = $urandom;
        end
        @(negedge clk);
        chk("hit_ack", cpu_data_ack_o, hit);
        if (hit) begin
            chk("hit_data", cpu_rd_data_o, rdata);
            return;
        end
        chk("miss_addr_ack", cpu_addr_ack_o, 0);
        chk("miss_rd_data", cpu_rd_data_o, 0);
        chk("miss_wr_req", ram_wr_req_o, 0);

        if (wb) begin
            for (int i = 0; i <= wb_dly; i++) begin
                @(negedge clk);
                chk("wb_req", ram_wr_req_o, 1);
                chk("wb_addr", ram_wr_addr_o, wb_addr);
                chk("wb_data", ram_wr_data_o, wb_line);
                chk("wb_no_rd_req", ram_rd_req_o, 0);
                chk("wb_addr_ack", cpu_addr_ack_o, 0);
                if (i == wb_dly) ram_wr_rdy_i = 1'b1;
            end
            @(posedge clk); #1;
            ram_wr_rdy_i = 1'b0;
        end

        pend = 1'b1; beat = 0; hs_wait = $urandom_range(0, 2);
        while (beat < LW) begin
            @(negedge clk);
            chk("rf_rd_req", ram_rd_req_o, pend);
            if (pend) chk("rf_rd_addr", ram_rd_addr_o, rd_addr);
            chk("rf_wr_req", ram_wr_req_o, 0);
            chk("rf_addr_ack", cpu_addr_ack_o, 0);
            if (pend) begin
                if (hs_wait == 0) ram_rd_rdy_i = 1'b1;
                else hs_wait--;
            end
            if ((!pend || ram_rd_rdy_i) && $urandom_range(0, 2) != 0) begin
                ram_rd_valid_i = 1'b1;
                ram_rd_data_i  = fill[beat*32 +: 32];
            end
            @(posedge clk); #1;
            if (ram_rd_rdy_i) pend = 1'b0;
            if (ram_rd_valid_i) beat++;
            ram_rd_rdy_i = 1'b0; ram_rd_valid_i = 1'b0;
            if (abort_beats >= 0 && beat == abort_beats) begin
                rst_n = 1'b0; cpu_req_i = 1'b0;
                @(negedge clk);
                @(posedge clk); #1;
                @(negedge clk);
                chk_all_zero("abort");
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_reset();
                return;
            end
        end

        @(negedge clk);
        chk("resp_ack", cpu_data_ack_o, 1);
        chk("resp_data", cpu_rd_data_o, rdata);
        chk("resp_addr_ack", cpu_addr_ack_o, 0);
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic pq_push(input bit op, input bit [31:0] addr, input bit [3:0] be, input bit [31:0] wd);
        pq_op.push_back(op); pq_addr.push_back(addr); pq_be.push_back(be); pq_wd.push_back(wd);
    endtask

    // Back-to-back hits from the pq_* queue, one completion per cycle
    task automatic run_pipe();
        bit [31:0]  exp_d [$];
        bit         hit, wb;
        bit [31:0]  wb_addr, rd_addr, rdata;
        bit [127:0] wb_line, fill;
        int         n;
        n = pq_op.size();
        for (int i = 0; i < n; i++) begin
            model_access(pq_op[i], pq_addr[i], pq_be[i], pq_wd[i],
                         hit, wb, wb_addr, wb_line, rd_addr, fill, rdata);
            exp_d.push_back(rdata);
        end
        @(posedge clk); #1;
        cpu_req_i = 1'b1; cpu_op_i = pq_op[0]; cpu_addr_i = pq_addr[0];
        cpu_wr_en_i = pq_be[0]; cpu_wr_data_i = pq_wd[0];
        @(negedge clk);
        chk("pipe_addr_ack0", cpu_addr_ack_o, 1);
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            cpu_op_i = pq_op[i]; cpu_addr_i = pq_addr[i];
            cpu_wr_en_i = pq_be[i]; cpu_wr_data_i = pq_wd[i];
            @(negedge clk);
            chk("pipe_data_ack", cpu_data_ack_o, 1);
            chk("pipe_data", cpu_rd_data_o, exp_d[i-1]);
            chk("pipe_addr_ack", cpu_addr_ack_o, 1);
        end
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
        @(negedge clk);
        chk("pipe_data_ack_last", cpu_data_ack_o, 1);
        chk("pipe_data_last", cpu_rd_data_o, exp_d[n-1]);
        @(negedge clk);
        chk("pipe_idle_ack", cpu_data_ack_o, 0);
        pq_op.delete(); pq_addr.delete(); pq_be.delete(); pq_wd.delete();
    endtask

    initial begin
        rst_n = 1'b0; cpu_req_i = 1'b0; cpu_op_i = 1'b0; cpu_addr_i = '0;
        cpu_wr_en_i = '0; cpu_wr_data_i = '0; ram_rd_rdy_i = 1'b0;
        ram_rd_data_i = '0; ram_rd_valid_i = 1'b0; ram_wr_rdy_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        mem[32'h1000] = 32'hA0; mem[32'h1004] = 32'hA1;
        mem[32'h1008] = 32'hA2; mem[32'h100C] = 32'hA3;

        // Cold miss then hit, byte-merge write, read-back
        access(1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, -1);
        access(1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, -1);
        access(1'b1, 32'h0000_1008, 4'b0011, 32'hDEAD_BEEF, 0, -1);
        access(1'b0, 32'h0000_1008, 4'h0, 32'h0, 0, -1);

        // LRU victim selection and dirty eviction under write-back backpressure
        access(1'b0, 32'h0000_2000, 4'h0, 32'h0, 0, -1);
        access(1'b0, 32'h0000_1000, 4'h0, 32'h0, 0, -1);
        access(1'b0, 32'h0000_3000, 4'h0, 32'h0, 0, -1);
        access(1'b0, 32'h0000_3000, 4'h0, 32'h0, 0, -1);
        access(1'b0, 32'h0000_2000, 4'h0, 32'h0, 5, -1);
        access(1'b0, 32'h0000_1000, 4'h0, 32'h0, 0, -1);

        pq_push(1'b0, 32'h0000_1000, 4'h0, 32'h0);
        pq_push(1'b0, 32'h0000_1004, 4'h0, 32'h0);
        pq_push(1'b0, 32'h0000_100C, 4'h0, 32'h0);
        run_pipe();
        pq_push(1'b1, 32'h0000_1004, 4'hF, 32'h1122_3344);
        pq_push(1'b0, 32'h0000_1004, 4'h0, 32'h0);
        pq_push(1'b0, 32'h0000_2000, 4'h0, 32'h0);
        run_pipe();

        // Reset in the middle of a refill, then the line must miss again
        access(1'b0, 32'h0000_4000, 4'h0, 32'h0, 1, 2);
        access(1'b0, 32'h0000_4000, 4'h0, 32'h0, 0, -1);
        access(1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, -1);

        for (int i = 0; i < 200; i++) begin
            bit [31:0] a;
            a = (32'($urandom_range(1, 5)) << 12) | (32'($urandom_range(0, 2)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            access(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                   $urandom_range(0, 3), -1);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache between the core load/store unit and the RAM interface module. It generalises the 2-way dcache in four ways: it adds configurable ways, sets, line length and data width, and true-LRU replacement with invalid-way-first victim selection. It also provides pipelined back-to-back hits and a single-beat line write-back handshake. Storage is held in flops, so tag, data and state reads are combinational from the registered request address.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width in bits; multiple of 8
WAYS, 2, associativity; 1, 2 or 4
SETS, 256, sets per way; power of 2
LINE_WORDS, 4, words per line; power of 2, at least 2
Derived parameters:
- OFF_W = log2(LINE_WORDS*DATA_W/8)
- IDX_W = log2(SETS)
- TAG_W = ADDR_W-IDX_W-OFF_W
- AGE_W = log2(WAYS); when WAYS=1, the LRU logic is removed

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_req_i  in  1  access request
cpu_op_i  in  1  1 = write, 0 = read
cpu_addr_i  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
cpu_wr_en_i  in  DATA_W/8  byte write strobes
cpu_wr_data_i  in  DATA_W  store data
cpu_rd_data_o  out  DATA_W  load data, valid while cpu_data_ack_o is 1
cpu_addr_ack_o  out  1  request accepted this cycle
cpu_data_ack_o  out  1  access complete this cycle
ram_rd_req_o  out  1  line refill request
ram_rd_addr_o  out  ADDR_W  line-aligned refill address
ram_rd_rdy_i  in  1  refill request accepted
ram_rd_data_i  in  DATA_W  refill beat
ram_rd_valid_i  in  1  refill beat valid
ram_wr_req_o  out  1  line write-back request
ram_wr_addr_o  out  ADDR_W  line-aligned write-back address
ram_wr_data_o  out  DATA_W*LINE_WORDS  victim line; word 0 in the LSBs
ram_wr_rdy_i  in  1  write-back accepted

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low.
- Reset state, applied on the first edge with rst_n=0:
  - state = IDLE
  - all valid and dirty bits = 0
  - age[set][w] = w
  - all outputs 0
- Reset during WRITEBACK or REFILL: the operation is abandoned, dirty data is lost, and request outputs are 0 on the next cycle.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
- Acceptance:
  - cpu_addr_ack_o = cpu_req_i when state is IDLE, or when state is LOOKUP and the access hits; 0 otherwise.
  - On acceptance, op, addr, strobes and data are captured into the request buffer, and the next state is LOOKUP.
- LOOKUP:
  - hit = valid && tag match, tested in every way.
  - On a hit, cpu_data_ack_o = 1 in this cycle and cpu_rd_data_o = the addressed word.
  - On a write hit, the strobed bytes are merged at the clock edge and dirty = 1.
  - LRU is updated on every hit.
  - Next state is LOOKUP if a new request was accepted this cycle, else IDLE.
  - Hit latency is 1 cycle after addr_ack. Back-to-back hits complete one per cycle. A read following a write to the same word returns the new data.
- Miss:
  - Victim = lowest-indexed invalid way; otherwise the way with age == WAYS-1.
  - Victim valid and dirty: go to WRITEBACK. Otherwise: go to REFILL.
  - The victim way is held in a miss register.
- WRITEBACK:
  - ram_wr_req_o = 1, with ram_wr_addr_o = {victim tag, index, 0} and ram_wr_data_o = victim line.
  - These outputs stay stable until the cycle where ram_wr_req_o && ram_wr_rdy_i, then go to REFILL.
  - No ram_rd_req_o is asserted before this handshake.
- REFILL:
  - ram_rd_req_o = 1, with ram_rd_addr_o = {req tag, index, 0}, until ram_rd_rdy_i is sampled 1; then the request drops.
  - Each ram_rd_valid_i beat writes word beat_cnt of the victim line; beat_cnt counts 0..LINE_WORDS-1.
  - A valid beat in the same cycle as the request handshake is accepted.
  - On the final beat, the tag is written and valid = 1.
  - For writes, the buffered strobed bytes are merged over the refilled word, and dirty = op.
  - LRU is updated, then go to RESP.
- RESP:
  - cpu_data_ack_o = 1, cpu_rd_data_o = the addressed word after the merge, cpu_addr_ack_o = 0.
  - Next state is IDLE.
- LRU update for accessed way a with old age k: age[a] = 0, and every way with age < k increments. Ages remain a permutation of 0..WAYS-1.
- cpu_rd_data_o is 0 whenever cpu_data_ack_o = 0. For writes its value on data_ack is the post-merge word.
- ram_rd_valid_i outside REFILL is ignored. cpu_req_i while a miss is outstanding is not acknowledged, and the CPU holds it.

Test Plan:
The default parameters place 0x1000, 0x2000 and 0x3000 all in set 0.
- Cold read miss: after reset, read 0x0000_1004 with beats 0xA0, 0xA1, 0xA2, 0xA3 -> no ram_wr_req_o, ram_rd_addr_o = 0x0000_1000, then RESP with data 0x0000_00A1. Re-reading the same address -> data_ack 1 cycle after addr_ack with 0x0000_00A1.
- Byte-merge write hit: write 0x0000_1008, strobe 4'b0011, data 0xDEAD_BEEF -> a following read returns 0x0000_BEEF.
- LRU victim selection: fill set 0 with 0x1000 (dirty from the test above) and 0x2000 (clean), touch 0x1000, then read 0x3000 -> clean 0x2000 is evicted with no write-back. Touching 0x3000 and then reading 0x2000 -> ram_wr_req_o with addr 0x1000 and data containing 0x0000_BEEF in word 2.
- Write-back backpressure: hold ram_wr_rdy_i low for 5 cycles -> ram_wr_req_o, addr and data stay stable and ram_rd_req_o stays 0 until the handshake.
- Pipelined hits: three consecutive read hits to 0x1000, 0x1004 and 0x100C -> cpu_data_ack_o high for 3 consecutive cycles with the correct words.
- Reset mid-refill: assert rst_n=0 after 2 refill beats -> on the next cycle all outputs are 0. A later access to that line misses.
